wb_cmd_master: RTL
==================

Name: wb_cmd_master

Overview:
- Wishbone classic single-transfer initiator; drives the GPIO peripheral's slave port (or any 8-bit Wishbone slave) from a simple valid/ready command stream.
- Returns a response stream carrying read data and a termination status.
- Handles err/rty terminations, bounded retry and a per-attempt bus timeout, so the host-side logic (test sequencer, UART bridge) never hangs on a dead slave.

Parameters:
- AW, 1, Wishbone address width.
- DW, 8, Wishbone data width.
- TIMEOUT, 255, cycles per attempt without ack/err/rty before abort; 0 disables the timeout.
- MAX_RETRY, 3, rty terminations retried before giving up; 0 means no retries.

Ports:
- wb_clk  in  1  clock; all logic is on the rising edge.
- wb_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_we  in  1  1=write, 0=read.
- cmd_adr  in  AW  target address.
- cmd_dat  in  DW  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when valid&ready.
- rsp_dat  out  DW  read data; 0 for writes and for failed reads.
- rsp_status  out  2  00 ok, 01 err, 10 timeout, 11 retry exhausted.
- wb_adr_o  out  AW  address.
- wb_dat_o  out  DW  write data.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_cti_o  out  3  constant 3'b000 (classic).
- wb_bte_o  out  2  constant 2'b00.
- wb_dat_i  in  DW  read data.
- wb_ack_i  in  1  normal termination.
- wb_err_i  in  1  error termination.
- wb_rty_i  in  1  retry termination.

Behaviour:
- Reset (async assert, sync deassert by design):
  - State IDLE.
  - cyc/stb/we, rsp_valid = 0; rsp_dat, rsp_status = 0; wb_adr_o, wb_dat_o = 0.
  - Retry and timeout counters = 0.
  - Reset mid-transfer drops cyc/stb immediately and discards the command and any pending response.
- All outputs are registered except cmd_ready, which is combinational (= state==IDLE).
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch we/adr/dat into wb_*_o, clear counters, go to BUS. cyc=stb=1 from the next cycle (cycle 1 after acceptance).
  - BUS: cyc=stb=1, address/data/we held stable. Termination sampled each cycle with priority err > ack > rty.
    - ack: capture wb_dat_i into rsp_dat if read (0 if write), status 00, go to RESP.
    - err: status 01, rsp_dat 0, go to RESP.
    - rty with retry_cnt < MAX_RETRY: retry_cnt++, go to GAP.
    - rty with retry_cnt == MAX_RETRY: status 11, go to RESP.
    - No termination: tmo_cnt++. When tmo_cnt reaches TIMEOUT-1 (i.e. TIMEOUT cycles in BUS without termination), status 10, go to RESP. Never times out when TIMEOUT=0.
    - cyc/stb deassert on the cycle after termination.
  - GAP: cyc=stb=0 for exactly one cycle, tmo_cnt cleared, then back to BUS with the same address/data.
  - RESP: rsp_valid=1, rsp_dat/rsp_status stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE; cmd_ready rises the following cycle.
- Ordering: exactly one response per accepted command, in order. No new command is accepted until the response is consumed.
- Latency: ack on cycle N of BUS gives rsp_valid on cycle N+1. Zero-wait slave: cmd accept at t0, cyc t1, ack t1, rsp_valid t2.
- Terminations arriving outside BUS are ignored.
- Counters: retry_cnt is ceil(log2(MAX_RETRY+1)) bits, minimum 1; tmo_cnt is 8 bits minimum, sized to TIMEOUT. No wrap occurs: both are bounded by their compare.

Test Plan:
- Write 0x5A to adr 1, slave acks on the first cycle -> wb_we_o=1, wb_dat_o=0x5A, cyc high for exactly 1 cycle; response status 00, rsp_dat 0x00 two cycles after accept.
- Read adr 0, slave waits 3 cycles, then ack with wb_dat_i=0xC3 -> cyc high 4 cycles; rsp_dat 0xC3, status 00; cmd_ready low throughout.
- MAX_RETRY=3, slave asserts rty on every attempt -> 4 BUS phases separated by 1-cycle cyc-low gaps, address/data unchanged; status 11.
- Slave asserts err and ack in the same cycle -> status 01, rsp_dat 0.
- TIMEOUT=4, slave never responds -> cyc high exactly 4 cycles; status 10.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_dat stable and cmd_ready stays 0.
- Assert wb_rst_n=0 mid-BUS -> cyc/stb 0 immediately; after release no response is produced and cmd_ready=1.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Purpose: Wishbone classic single-transfer initiator driven by a valid/ready command stream.
// Latency: cmd accept t0, cyc/stb t1, ack on BUS cycle N gives rsp_valid on cycle N+1.
// Backpressure: one command in flight; cmd_ready low from acceptance until the response is consumed.
//
// Ports:
//   wb_clk, wb_rst_n            clock, asynchronous active-low reset
//   cmd_valid/ready/we/adr/dat  command stream (1 = write)
//   rsp_valid/ready/dat/status  response stream; status 00 ok, 01 err, 10 timeout, 11 retry exhausted
//   wb_*_o / wb_*_i             Wishbone classic initiator signals (cti/bte tied to classic)

module wb_cmd_master #(
   parameter int AW        = 1,
   parameter int DW        = 8,
   parameter int TIMEOUT   = 255,
   parameter int MAX_RETRY = 3
) (
   input  logic          wb_clk,
   input  logic          wb_rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_we,
   input  logic [AW-1:0] cmd_adr,
   input  logic [DW-1:0] cmd_dat,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_dat,
   output logic [1:0]    rsp_status,
   output logic [AW-1:0] wb_adr_o,
   output logic [DW-1:0] wb_dat_o,
   output logic          wb_we_o,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   output logic [2:0]    wb_cti_o,
   output logic [1:0]    wb_bte_o,
   input  logic [DW-1:0] wb_dat_i,
   input  logic          wb_ack_i,
   input  logic          wb_err_i,
   input  logic          wb_rty_i
);

   // Counter widths: retry counter just wide enough for MAX_RETRY, timeout counter at least 8 bits.
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [TW-1:0] TMO_LAST  = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_ERR = 2'b01;
   localparam logic [1:0] ST_TMO = 2'b10;
   localparam logic [1:0] ST_EXH = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_GAP,
      S_RESP
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [RW-1:0]   retry_cnt;
   logic [TW-1:0]   tmo_cnt;

   // Decoded terminations with priority err > ack > rty.
   logic            term_err;
   logic            term_ack;
   logic            term_rty;
   logic            retry_left;
   logic            tmo_hit;

   assign cmd_ready = (state == S_IDLE);
   assign wb_cti_o  = 3'b000;
   assign wb_bte_o  = 2'b00;

   always_comb begin
      term_err   = wb_err_i;
      term_ack   = !wb_err_i && wb_ack_i;
      term_rty   = !wb_err_i && !wb_ack_i && wb_rty_i;
      retry_left = (retry_cnt < RETRY_MAX);
      // Timeout fires on the TIMEOUT-th silent BUS cycle; disabled entirely when TIMEOUT is 0.
      tmo_hit    = (TIMEOUT != 0) && !wb_err_i && !wb_ack_i && !wb_rty_i && (tmo_cnt == TMO_LAST);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cmd_valid) state_nxt = S_BUS;
         end
         S_BUS: begin
            if (term_err || term_ack)  state_nxt = S_RESP;
            else if (term_rty)         state_nxt = retry_left ? S_GAP : S_RESP;
            else if (tmo_hit)          state_nxt = S_RESP;
         end
         S_GAP: begin
            state_nxt = S_BUS;
         end
         S_RESP: begin
            if (rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state      <= S_IDLE;
         wb_cyc_o   <= 1'b0;
         wb_stb_o   <= 1'b0;
         wb_we_o    <= 1'b0;
         wb_adr_o   <= '0;
         wb_dat_o   <= '0;
         rsp_valid  <= 1'b0;
         rsp_dat    <= '0;
         rsp_status <= ST_OK;
         retry_cnt  <= '0;
         tmo_cnt    <= '0;
      end else begin
         state     <= state_nxt;
         // cyc/stb/rsp_valid are registered copies of the upcoming state, so they
         // change on the same edge as the state itself.
         wb_cyc_o  <= (state_nxt == S_BUS);
         wb_stb_o  <= (state_nxt == S_BUS);
         rsp_valid <= (state_nxt == S_RESP);

         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  wb_we_o   <= cmd_we;
                  wb_adr_o  <= cmd_adr;
                  wb_dat_o  <= cmd_dat;
                  retry_cnt <= '0;
                  tmo_cnt   <= '0;
               end
            end
            S_BUS: begin
               if (term_err) begin
                  rsp_status <= ST_ERR;
                  rsp_dat    <= '0;
               end else if (term_ack) begin
                  rsp_status <= ST_OK;
                  rsp_dat    <= wb_we_o ? '0 : wb_dat_i;
               end else if (term_rty) begin
                  if (retry_left) begin
                     retry_cnt <= retry_cnt + RW'(1);
                  end else begin
                     rsp_status <= ST_EXH;
                     rsp_dat    <= '0;
                  end
               end else if (tmo_hit) begin
                  rsp_status <= ST_TMO;
                  rsp_dat    <= '0;
               end else if (TIMEOUT != 0) begin
                  // Bounded by TMO_LAST, so this never wraps.
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            S_GAP: begin
               tmo_cnt <= '0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
